mtsp_bus_master: RTL and testbench

MTSP_BUS_MASTER -- requirements
Module: mtsp_bus_master

---
 rtl/mtsp_bus_master.sv | 138 +++++++++++++
 tb/tb_mtsp_bus_master.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mtsp_bus_master.sv
// Splits one 128-bit command into four 32-bit bus beats and reassembles read data.
// Optional per-beat ACK timeout is enabled by defining MTSP_BUS_TIMEOUT_EN.
module mtsp_bus_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         CMD_EN,
  input  logic         CMD_WRITE,
  input  logic [13:0]  CMD_ADDR,
  input  logic [127:0] CMD_DATA,
  output logic         CMD_VALID,
  input  logic [13:0]  BASE_ADDR,
  output logic         BUS_REQ,
  output logic         BUS_WE,
  output logic [31:0]  BUS_ADDR,
  output logic [31:0]  BUS_WDATA,
  input  logic         BUS_ACK,
  input  logic [31:0]  BUS_RDATA,
  output logic         RD_VALID,
  output logic [127:0] RD_DATA,
  output logic         BUSY,
  output logic         ERR,
  input  logic         ERR_CLR
);

  typedef enum logic [1:0] {IDLE, BEAT, DONE} state_t;

  state_t       state;
  logic [1:0]   beat;
  logic [6:0]   lane_lo;
  logic         bus_req_q;
  logic         cmd_valid_q;
  logic         rd_valid_q;
  logic         busy_q;
  logic [127:0] rd_data_q;
  logic         abort;

  // Beat 0 maps to the top lane (X), beat 3 to the bottom lane (W).
  assign lane_lo   = {~beat, 5'b0};

  assign BUS_REQ   = bus_req_q;
  assign BUS_WE    = bus_req_q & CMD_WRITE;
  assign BUS_ADDR  = {BASE_ADDR, CMD_ADDR, beat, 2'b00};
  assign BUS_WDATA = CMD_DATA[lane_lo +: 32];
  assign CMD_VALID = cmd_valid_q;
  assign RD_VALID  = rd_valid_q;
  assign RD_DATA   = rd_data_q;
  assign BUSY      = busy_q;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state       <= IDLE;
      beat        <= 2'd0;
      bus_req_q   <= 1'b0;
      cmd_valid_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      cmd_valid_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (CMD_EN) begin
            state     <= BEAT;
            beat      <= 2'd0;
            bus_req_q <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        BEAT: begin
          if (BUS_ACK) begin
            if (!CMD_WRITE) rd_data_q[lane_lo +: 32] <= BUS_RDATA;
            if (beat == 2'd3) begin
              state       <= DONE;
              bus_req_q   <= 1'b0;
              cmd_valid_q <= 1'b1;
              rd_valid_q  <= ~CMD_WRITE;
            end else begin
              beat <= beat + 2'd1;
            end
          end else if (abort) begin
            // Lanes from the stalled beat onward were never read; report them as zero.
            if (!CMD_WRITE) begin
              for (int i = 0; i < 4; i++) begin
                if (i >= int'(beat)) rd_data_q[(3 - i) * 32 +: 32] <= 32'd0;
              end
            end
            state       <= DONE;
            bus_req_q   <= 1'b0;
            cmd_valid_q <= 1'b1;
            rd_valid_q  <= ~CMD_WRITE;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          bus_req_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

`ifdef MTSP_BUS_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TW-1:0] to_cnt;
  logic          err_q;

  // Abort on the TIMEOUT_CYCLES-th consecutive un-acked cycle of a beat.
  assign abort = (state == BEAT) && !BUS_ACK && (to_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign ERR   = err_q;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state != BEAT || BUS_ACK || abort) to_cnt <= '0;
      else                                   to_cnt <= to_cnt + 1'b1;
      if (abort)        err_q <= 1'b1;
      else if (ERR_CLR) err_q <= 1'b0;
    end
  end
`else
  logic unused_cfg;

  assign abort      = 1'b0;
  assign ERR        = 1'b0;
  assign unused_cfg = ERR_CLR | (TIMEOUT_CYCLES == 0);
`endif

endmodule

// File: tb/tb_mtsp_bus_master.sv
// Bench for mtsp_bus_master: vector table plus scoreboard of expected pops,
// a bus responder with programmable wait states, and reset/timeout sequences.
module tb_mtsp_bus_master;

  logic         CLK = 1'b0;
  logic         nRST = 1'b0;
  logic         CMD_EN = 1'b0;
  logic         CMD_WRITE = 1'b0;
  logic [13:0]  CMD_ADDR = '0;
  logic [127:0] CMD_DATA = '0;
  logic [13:0]  BASE_ADDR = '0;
  logic         BUS_ACK = 1'b0;
  logic [31:0]  BUS_RDATA = '0;
  logic         ERR_CLR = 1'b0;
  logic         CMD_VALID, BUS_REQ, BUS_WE, RD_VALID, BUSY, ERR;
  logic [31:0]  BUS_ADDR, BUS_WDATA;
  logic [127:0] RD_DATA;

  mtsp_bus_master #(.TIMEOUT_CYCLES(8)) dut (
    .CLK(CLK), .nRST(nRST), .CMD_EN(CMD_EN), .CMD_WRITE(CMD_WRITE),
    .CMD_ADDR(CMD_ADDR), .CMD_DATA(CMD_DATA), .CMD_VALID(CMD_VALID),
    .BASE_ADDR(BASE_ADDR), .BUS_REQ(BUS_REQ), .BUS_WE(BUS_WE),
    .BUS_ADDR(BUS_ADDR), .BUS_WDATA(BUS_WDATA), .BUS_ACK(BUS_ACK),
    .BUS_RDATA(BUS_RDATA), .RD_VALID(RD_VALID), .RD_DATA(RD_DATA),
    .BUSY(BUSY), .ERR(ERR), .ERR_CLR(ERR_CLR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit           we;
    logic [13:0]  base;
    logic [13:0]  addr;
    logic [127:0] data;
    logic [127:0] rdata;
    int           waits;
    bit           b2b;
  } vec_t;

  typedef struct {
    bit           rdv;
    logic [127:0] rd;
    int           lat;
  } exp_t;

  exp_t         sbq[$];
  int           tests = 0;
  int           fails = 0;
  int           cyc = 0;
  bit           cur_we = 1'b0;
  logic [13:0]  cur_base = '0;
  logic [13:0]  cur_addr = '0;
  logic [127:0] cur_data = '0;
  logic [127:0] cur_rdata = '0;
  int           cur_waits = 0;
  int           cur_hang = -1;
  logic [127:0] rd_model = '0;
  int           t_start = 0;
  int           exp_beat = 0;
  bit           prev_req = 1'b0;
  int           wcnt = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] lane(logic [127:0] d, int i);
    return d[127 - 32 * i -: 32];
  endfunction

  // Monitor, scoreboard pop and bus responder, all on the falling edge.
  always @(negedge CLK) begin
    exp_t e;
    if (BUS_ACK && prev_req) exp_beat++;
    if (BUS_REQ && !prev_req) exp_beat = 0;
    if (BUS_REQ) begin
      check("bus_addr", BUS_ADDR, {cur_base, cur_addr, exp_beat[1:0], 2'b00});
      check("bus_we", BUS_WE, cur_we);
      if (cur_we) check("bus_wdata", BUS_WDATA, lane(cur_data, exp_beat));
    end
    if (RD_VALID) check("rd_valid_with_pop", CMD_VALID, 1'b1);
    if (CMD_VALID) begin
      if (sbq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pop: got pop at cycle %0d expected none", cyc);
      end else begin
        e = sbq.pop_front();
        check("rd_valid", RD_VALID, e.rdv);
        check("rd_data", RD_DATA, e.rd);
        check("latency", cyc - t_start + 1, e.lat);
      end
    end
    if (!BUSY && CMD_EN && nRST) t_start = cyc;
    if (!BUS_REQ || !nRST) begin
      BUS_ACK = 1'b0;
      wcnt = 0;
    end else begin
      if (BUS_ACK) wcnt = 0;
      if (exp_beat == cur_hang) begin
        BUS_ACK = 1'b0;
      end else if (wcnt >= cur_waits) begin
        BUS_ACK = 1'b1;
        BUS_RDATA = lane(cur_rdata, exp_beat);
      end else begin
        BUS_ACK = 1'b0;
        wcnt++;
      end
    end
    prev_req = BUS_REQ;
  end

  task automatic issue(vec_t v, bit push);
    CMD_WRITE = v.we;
    BASE_ADDR = v.base;
    CMD_ADDR  = v.addr;
    CMD_DATA  = v.data;
    cur_we    = v.we;
    cur_base  = v.base;
    cur_addr  = v.addr;
    cur_data  = v.data;
    cur_rdata = v.rdata;
    cur_waits = v.waits;
    CMD_EN    = 1'b1;
    if (push) begin
      if (!v.we) rd_model = v.rdata;
      sbq.push_back('{rdv: !v.we, rd: rd_model, lat: 6 + 4 * v.waits});
    end
  endtask

  task automatic wait_pop(string name);
    bit got = 1'b0;
    for (int k = 0; k < 400 && !got; k++) begin
      @(negedge CLK);
      if (CMD_VALID) got = 1'b1;
    end
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL %s_pop: got no pop expected one within 400 cycles", name);
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish before 400000");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    vec_t v;
    bit   found;

    vecs[0] = '{1'b1, 14'h0001, 14'h0010,
                128'h11111111_22222222_33333333_44444444, 128'h0, 0, 1'b0};
    vecs[1] = '{1'b0, 14'h0001, 14'h0020, 128'h0,
                128'h000000A0_000000A1_000000A2_000000A3, 2, 1'b0};
    vecs[2] = '{1'b1, 14'h2AAA, 14'h1555,
                128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF, 128'h0, 1, 1'b0};
    vecs[3] = '{1'b0, 14'h0005, 14'h0100, 128'h0,
                128'h10203040_50607080_90A0B0C0_D0E0F000, 0, 1'b0};
    vecs[4] = '{1'b0, 14'h0005, 14'h0101, 128'h0,
                128'hF1E2D3C4_B5A69788_796A5B4C_3D2E1F00, 0, 1'b1};
    vecs[5] = '{1'b1, 14'h3FFF, 14'h3FFF,
                128'hAAAA5555_5555AAAA_FFFF0000_0000FFFF, 128'h0, 3, 1'b1};
    vecs[6] = '{1'b0, 14'h3FFF, 14'h3FFF, 128'h0,
                128'h80000001_7FFFFFFE_00000000_FFFFFFFF, 0, 1'b0};

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_bus_req", BUS_REQ, 1'b0);
    check("rst_cmd_valid", CMD_VALID, 1'b0);
    check("rst_rd_valid", RD_VALID, 1'b0);
    check("rst_busy", BUSY, 1'b0);
    check("rst_err", ERR, 1'b0);
    check("rst_rd_data", RD_DATA, 128'h0);
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check("idle_no_cmd_busy", BUSY, 1'b0);

    for (int i = 0; i < 7; i++) begin
      if (!vecs[i].b2b) begin
        CMD_EN = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
      end
      issue(vecs[i], 1'b1);
      wait_pop($sformatf("vec%0d", i));
    end
    CMD_EN = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("sb_drain", sbq.size(), 0);

    // Reset in the middle of beat 2 of a read, then restart the same command.
    v = '{1'b0, 14'h0123, 14'h0ABC, 128'h0,
          128'h0BADF00D_12345678_9ABCDEF0_0F1E2D3C, 2, 1'b0};
    issue(v, 1'b0);
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      @(negedge CLK);
      if (BUS_REQ && BUS_ADDR[3:2] == 2'd2) found = 1'b1;
    end
    if (!found) begin
      tests++;
      fails++;
      $display("FAIL rst_mid_beat2: got no beat 2 expected one within 100 cycles");
    end
    nRST = 1'b0;
    @(negedge CLK);
    check("mid_rst_bus_req", BUS_REQ, 1'b0);
    check("mid_rst_busy", BUSY, 1'b0);
    check("mid_rst_cmd_valid", CMD_VALID, 1'b0);
    check("mid_rst_rd_data", RD_DATA, 128'h0);
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    rd_model = v.rdata;
    sbq.push_back('{rdv: 1'b1, rd: rd_model, lat: 14});
    wait_pop("restart");
    CMD_EN = 1'b0;
    repeat (2) @(posedge CLK);
    #1;

`ifdef MTSP_BUS_TIMEOUT_EN
    // Beat 1 is never acknowledged: abort after 8 wait cycles, lanes 1..3 zero.
    v = '{1'b0, 14'h0042, 14'h0777, 128'h0,
          128'hA5A5A5A5_B6B6B6B6_C7C7C7C7_D8D8D8D8, 0, 1'b0};
    cur_hang = 1;
    issue(v, 1'b0);
    rd_model = {v.rdata[127:96], 96'h0};
    sbq.push_back('{rdv: 1'b1, rd: rd_model, lat: 11});
    wait_pop("timeout");
    CMD_EN = 1'b0;
    cur_hang = -1;
    check("timeout_err_set", ERR, 1'b1);
    @(posedge CLK);
    #1;
    check("timeout_err_sticky", ERR, 1'b1);
    ERR_CLR = 1'b1;
    @(posedge CLK);
    #1;
    ERR_CLR = 1'b0;
    check("err_clr", ERR, 1'b0);
`else
    ERR_CLR = 1'b1;
    @(posedge CLK);
    #1;
    ERR_CLR = 1'b0;
    check("err_const", ERR, 1'b0);
`endif

    repeat (2) @(posedge CLK);
    #1;
    check("sb_final_drain", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
